// File: rtl/lb2apb_pkg.sv
// lb2apb_pkg: shared definitions for the lb -> APB4 bridge.
//   state_e        bridge FSM states (IDLE, SETUP, ACCESS, DONE)
//   PPROT_DEFAULT  constant APB protection attribute
//   TIMEOUT_RDATA  read-data fill pattern returned by an aborted read
//                  (only used when LB2APB_TIMEOUT_EN is defined)
package lb2apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [2:0]  PPROT_DEFAULT = 3'b000;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/lb2apb.sv
// lb2apb: local-bus responder / APB4 initiator bridge.
// Each lb write or read request becomes exactly one APB transfer; the lb
// side sees a one-cycle lb_wready / lb_rvalid completion pulse. No
// pipelining: at most one transfer every four cycles. Every output is
// driven from a register.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   lb_waddr/wdata/wstrb/wen  lb write request (held until lb_wready)
//   lb_wready                 write-complete pulse
//   lb_raddr/ren              lb read request (held until lb_rvalid)
//   lb_rdata/rvalid           read data + read-complete pulse
//   lb_err                    error pulse (only with LB2APB_TIMEOUT_EN)
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   APB initiator outputs
//   prdata/pready/pslverr     APB responder inputs
//
// Build option: define LB2APB_TIMEOUT_EN to abort ACCESS phases that last
// TIMEOUT_CYCLES cycles and to report pslverr/timeouts on lb_err.
module lb2apb
  import lb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned STRB_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lb_waddr,
  input  logic [DATA_W-1:0] lb_wdata,
  input  logic              lb_wen,
  input  logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wready,
  input  logic [ADDR_W-1:0] lb_raddr,
  input  logic              lb_ren,
  output logic [DATA_W-1:0] lb_rdata,
  output logic              lb_rvalid,
`ifdef LB2APB_TIMEOUT_EN
  output logic              lb_err,
`endif
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  output logic [2:0]        pprot,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                wready_q, wready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef LB2APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // 32'hDEADBEEF replicated across DATA_W, low bits kept for narrow buses.
  function automatic logic [DATA_W-1:0] timeout_fill();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DATA_W; i++) v[i] = TIMEOUT_RDATA[i[4:0]];
    return v;
  endfunction

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = timeout_fill();

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // Without the timeout option the limit and the error input have no effect.
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_pslverr;
  assign unused_pslverr = pslverr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef LB2APB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
`ifdef LB2APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // APB controls are computed one state ahead so that the registered
  // psel/penable line up with SETUP/ACCESS and drop as DONE is entered.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
`ifdef LB2APB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Write has priority; a concurrent read waits for the next IDLE.
        if (lb_wen) begin
          paddr_d  = lb_waddr;
          pwdata_d = lb_wdata;
          pstrb_d  = lb_wstrb;
          pwrite_d = 1'b1;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end else if (lb_ren) begin
          paddr_d  = lb_raddr;
          pstrb_d  = '0;
          pwrite_d = 1'b0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef LB2APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          wready_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          if (!pwrite_q) rdata_d = prdata;
`ifdef LB2APB_TIMEOUT_EN
          err_d     = pslverr;
`endif
          state_d   = DONE;
        end
`ifdef LB2APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            wready_d  = pwrite_q;
            rvalid_d  = !pwrite_q;
            if (!pwrite_q) rdata_d = TIMEOUT_FILL;
            err_d     = 1'b1;
            state_d   = DONE;
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = PPROT_DEFAULT;
  assign lb_wready = wready_q;
  assign lb_rvalid = rvalid_q;
  assign lb_rdata  = rdata_q;
`ifdef LB2APB_TIMEOUT_EN
  assign lb_err    = err_q;
`endif

endmodule
